cache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate controller that drives the cachemem data/tag array and talks to main memory.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_ctrl.sv | 137 +++++++++++++
 tb/tb_cache_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and field geometry for the direct-mapped cache controller.
package cache_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int INDEX_W   = 12;
    localparam int TAG_W     = 18;
    localparam int TAG_LSB   = 14;
    localparam int INDEX_LSB = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WBACK,
        S_FILL,
        S_ALLOC,
        S_DONE
    } cache_state_e;

endpackage

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate controller, one-word lines.
// Drives the cachemem arrays and the main-memory bus, one request at a time.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cm_en,
    output logic [3:0]        cm_we,
    output logic              cm_allocate,
    output logic [ADDR_W-1:0] cm_addr,
    output logic [DATA_W-1:0] cm_wdata,
    input  logic [DATA_W-1:0] cm_rdata,
    input  logic              cm_hit,
    input  logic              cm_dirty,
    input  logic [TAG_W-1:0]  cm_vtag,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    cache_state_e state, state_nx;

    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] vic_addr;
    logic [DATA_W-1:0] vic_data;
    logic [DATA_W-1:0] fill_data;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (cpu_req) state_nx = S_COMPARE;
            S_COMPARE: begin
                if (cm_hit)        state_nx = S_DONE;
                else if (cm_dirty) state_nx = S_WBACK;
                else               state_nx = S_FILL;
            end
            S_WBACK:   if (mem_ack) state_nx = S_FILL;
            S_FILL:    if (mem_ack) state_nx = S_ALLOC;
            S_ALLOC:   state_nx = S_COMPARE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Datapath registers; reset drops any in-flight miss on the floor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_addr  <= '0;
            req_we    <= '0;
            req_wdata <= '0;
            vic_addr  <= '0;
            vic_data  <= '0;
            fill_data <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                    end
                end
                S_COMPARE: begin
                    if (cm_hit) begin
                        rdata_q <= cm_rdata;
                    end else if (cm_dirty) begin
                        vic_addr <= {cm_vtag,
                                     req_addr[TAG_LSB-1:INDEX_LSB],
                                     2'b00};
                        vic_data <= cm_rdata;
                    end
                end
                S_FILL: begin
                    if (mem_ack) fill_data <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_ack     = 1'b0;
        cm_en       = 1'b0;
        cm_we       = 4'h0;
        cm_allocate = 1'b0;
        cm_addr     = req_addr;
        cm_wdata    = req_wdata;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (state)
            S_COMPARE: begin
                cm_en = 1'b1;
                cm_we = cm_hit ? req_we : 4'h0;
            end
            S_WBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = vic_addr;
                mem_wdata = vic_data;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
            end
            // Fill installs the whole word; store bytes merge on the retry.
            S_ALLOC: begin
                cm_en       = 1'b1;
                cm_allocate = 1'b1;
                cm_we       = 4'hF;
                cm_wdata    = fill_data;
            end
            S_DONE:  cpu_ack = 1'b1;
            default: ;
        endcase
    end

    assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with behavioural cachemem and main memory.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cm_en;
    logic [3:0]  cm_we;
    logic        cm_allocate;
    logic [31:0] cm_addr;
    logic [31:0] cm_wdata;
    logic [31:0] cm_rdata;
    logic        cm_hit;
    logic        cm_dirty;
    logic [17:0] cm_vtag;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cm_en(cm_en), .cm_we(cm_we), .cm_allocate(cm_allocate),
        .cm_addr(cm_addr), .cm_wdata(cm_wdata), .cm_rdata(cm_rdata),
        .cm_hit(cm_hit), .cm_dirty(cm_dirty), .cm_vtag(cm_vtag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // Cachemem model: combinational lookup, posedge update
    bit        cv   [4096];
    bit        cd   [4096];
    bit [17:0] ctag [4096];
    bit [31:0] cdata[4096];
    logic [11:0] cm_idx;

    assign cm_idx   = cm_addr[13:2];
    assign cm_rdata = cdata[cm_idx];
    assign cm_vtag  = ctag[cm_idx];
    assign cm_dirty = cv[cm_idx] && cd[cm_idx];
    assign cm_hit   = cm_en && cv[cm_idx] && (ctag[cm_idx] == cm_addr[31:14]);

    always @(posedge clk) begin
        logic [31:0] merged;
        merged = cdata[cm_idx];
        if (cm_en && cm_allocate) begin
            cv[cm_idx]    <= 1'b1;
            cd[cm_idx]    <= 1'b0;
            ctag[cm_idx]  <= cm_addr[31:14];
            cdata[cm_idx] <= cm_wdata;
        end else if (cm_en && cm_we != 4'h0 && cm_hit) begin
            for (int b = 0; b < 4; b++)
                if (cm_we[b]) merged[8*b +: 8] = cm_wdata[8*b +: 8];
            cdata[cm_idx] <= merged;
            cd[cm_idx]    <= 1'b1;
        end
    end

    // Main memory model with fixed response latency and a transaction log
    logic [31:0] mem_arr[logic [31:0]];
    logic [64:0] mem_log[$];
    int mem_lat = 3;
    int mem_cnt = 0;

    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (!mem_req || mem_ack) begin
            mem_cnt <= 0;
        end else if (mem_cnt >= mem_lat - 1) begin
            mem_ack <= 1'b1;
            mem_cnt <= 0;
            if (mem_we) begin
                mem_arr[mem_addr] = mem_wdata;
                mem_log.push_back({1'b1, mem_addr, mem_wdata});
            end else begin
                mem_rdata <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
                mem_log.push_back({1'b0, mem_addr, 32'h0});
            end
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    // Scoreboard: {is_load, expected rdata}
    logic [32:0] sb_q[$];
    int ack_cnt = 0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (cpu_ack) begin
            ack_cnt++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                if (e[32]) chk("load_rdata", cpu_rdata, e[31:0]);
            end
        end
        if (cm_we != 4'h0 && !cm_allocate)
            chk("cm_we_on_miss", {31'd0, cm_hit}, 32'd1);
    end

    task automatic do_op(input string tag, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int exp_lat,
                         input int exp_mem);
        int n;
        int a0;
        mem_log.delete();
        a0 = ack_cnt;
        sb_q.push_back({we == 4'h0, exp_rd});
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (cpu_ack) break;
        end
        cpu_req = 1'b0;
        if (n >= 100) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_lat"}, n, exp_lat);
        repeat (3) @(negedge clk);
        chk({tag, "_acks"}, ack_cnt - a0, 32'd1);
        chk({tag, "_memtx"}, mem_log.size(), exp_mem);
    endtask

    task automatic exp_mem(input string tag, input int i, input logic we,
                           input logic [31:0] addr, input logic [31:0] d);
        if (i >= mem_log.size()) begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_we"}, {31'd0, mem_log[i][64]}, {31'd0, we});
            chk({tag, "_addr"}, mem_log[i][63:32], addr);
            if (we) chk({tag, "_data"}, mem_log[i][31:0], d);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ack"}, {31'd0, cpu_ack}, 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_cm_en"}, {31'd0, cm_en}, 32'd0);
        chk({tag, "_cm_we"}, {28'd0, cm_we}, 32'd0);
        chk({tag, "_cm_alloc"}, {31'd0, cm_allocate}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int n;
        int a0;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 4'h0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        mem_arr[32'h0000_0040] = 32'hDEAD_BEEF;
        mem_arr[32'h0000_4040] = 32'hCAFE_F00D;
        mem_arr[32'h0000_0080] = 32'h5555_5555;
        mem_arr[32'h0000_00C0] = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        do_op("cold_rd", 4'h0, 32'h40, 32'h0, 32'hDEAD_BEEF, 8, 1);
        exp_mem("cold_fill", 0, 1'b0, 32'h40, 32'h0);
        do_op("hit_rd", 4'h0, 32'h40, 32'h0, 32'hDEAD_BEEF, 2, 0);
        do_op("hit_st", 4'b0010, 32'h40, 32'h0000_AB00, 32'h0, 2, 0);
        do_op("rd_back", 4'h0, 32'h40, 32'h0, 32'hDEAD_ABEF, 2, 0);
        do_op("dirty_rd", 4'h0, 32'h4040, 32'h0, 32'hCAFE_F00D, 12, 2);
        exp_mem("wb", 0, 1'b1, 32'h40, 32'hDEAD_ABEF);
        exp_mem("wb_fill", 1, 1'b0, 32'h4040, 32'h0);
        do_op("st_miss", 4'hF, 32'h80, 32'h1234_5678, 32'h0, 8, 1);
        exp_mem("st_fill", 0, 1'b0, 32'h80, 32'h0);
        do_op("st_rd", 4'h0, 32'h82, 32'h0, 32'h1234_5678, 2, 0);
        do_op("refetch", 4'h0, 32'h40, 32'h0, 32'hDEAD_ABEF, 8, 1);
        exp_mem("refetch_fill", 0, 1'b0, 32'h40, 32'h0);

        // Reset in the middle of a fill
        mem_lat = 10;
        a0 = ack_cnt;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 4'h0;
        cpu_addr = 32'hC0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_fill", {31'd0, mem_req}, 32'd1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_ack", ack_cnt - a0, 32'd0);
        chk("abort_no_install", {31'd0, cv[12'h030]}, 32'd0);
        mem_lat = 3;
        do_op("post_abort", 4'h0, 32'hC0, 32'h0, 32'h0BAD_F00D, 8, 1);
        exp_mem("post_abort_fill", 0, 1'b0, 32'hC0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
